// File: rtl/axi_sram_slave_if.sv
// AXI4 bus bundle between a master and axi_sram_slave.
// The master modport drives requests; the slave modport drives the ready and response channels.
interface axi_sram_slave_if #(
    parameter int unsigned addr_wid = 26,
    parameter int unsigned data_wid = 32,
    parameter int unsigned id_wid   = 4
);
    localparam int unsigned stroblen = data_wid / 8;

    logic [id_wid-1:0]   awid;
    logic [addr_wid-1:0] awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [data_wid-1:0] wdata;
    logic [stroblen-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [id_wid-1:0]   bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [id_wid-1:0]   arid;
    logic [addr_wid-1:0] araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [id_wid-1:0]   rid;
    logic [data_wid-1:0] rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 slave that sequences write/read bursts onto a byte-addressed single-port SRAM.
// One transaction in flight at a time; AW/AR arbitration alternates when both are valid.
module axi_sram_slave #(
    parameter int unsigned addr_wid = 26,
    parameter int unsigned data_wid = 32,
    parameter int unsigned id_wid   = 4,
    parameter int unsigned stroblen = data_wid / 8
) (
    input  logic                aclk,
    input  logic                aresetn,
    axi_sram_slave_if.slave     bus,
    output logic [data_wid-1:0] mem_d,
    output logic [addr_wid-1:0] mem_addr,
    output logic                mem_wen,
    output logic [stroblen-1:0] mem_be,
    output logic                mem_ceb,
    input  logic [data_wid-1:0] mem_q
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_DATA = 3'd1;
    localparam logic [2:0] WR_RESP = 3'd2;
    localparam logic [2:0] RD_REQ  = 3'd3;
    localparam logic [2:0] RD_DATA = 3'd4;

    localparam int unsigned lane_bits = $clog2(stroblen);

    logic [2:0]          state_q, state_d;
    logic [id_wid-1:0]   id_q, id_d;
    logic [addr_wid-1:0] addr_q, addr_d, addr_step;
    logic [7:0]          len_q, len_d, beat_q, beat_d;
    logic [2:0]          size_q, size_d;
    logic                fixed_q, fixed_d, err_q, err_d, last_w_q, last_w_d;
    logic                grant_w, grant_r, beat_last;

    assign grant_w   = bus.awvalid & (~bus.arvalid | ~last_w_q);
    assign grant_r   = bus.arvalid & (~bus.awvalid | last_w_q);
    assign beat_last = (beat_q == len_q);

    // Erroneous bursts still walk the address as INCR at full bus width.
    assign addr_step = err_q   ? addr_wid'(stroblen) :
                       fixed_q ? '0 : (addr_wid'(1) << size_q);

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        addr_d   = addr_q;
        len_d    = len_q;
        beat_d   = beat_q;
        size_d   = size_q;
        fixed_d  = fixed_q;
        err_d    = err_q;
        last_w_d = last_w_q;
        case (state_q)
            IDLE: begin
                if (grant_w) begin
                    id_d     = bus.awid;
                    addr_d   = bus.awaddr;
                    len_d    = bus.awlen;
                    size_d   = bus.awsize;
                    fixed_d  = (bus.awburst == 2'b00);
                    err_d    = bus.awburst[1] | (bus.awsize > 3'(lane_bits));
                    beat_d   = '0;
                    last_w_d = 1'b1;
                    state_d  = WR_DATA;
                end else if (grant_r) begin
                    id_d     = bus.arid;
                    addr_d   = bus.araddr;
                    len_d    = bus.arlen;
                    size_d   = bus.arsize;
                    fixed_d  = (bus.arburst == 2'b00);
                    err_d    = bus.arburst[1] | (bus.arsize > 3'(lane_bits));
                    beat_d   = '0;
                    last_w_d = 1'b0;
                    state_d  = RD_REQ;
                end
            end
            WR_DATA: begin
                if (bus.wvalid) begin
                    if (bus.wlast != beat_last) err_d = 1'b1;
                    if (beat_last) begin
                        state_d = WR_RESP;
                    end else begin
                        beat_d = beat_q + 8'd1;
                        addr_d = addr_q + addr_step;
                    end
                end
            end
            WR_RESP: if (bus.bready) state_d = IDLE;
            RD_REQ:  state_d = RD_DATA;
            RD_DATA: begin
                if (bus.rready) begin
                    if (beat_last) begin
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        addr_d  = addr_q + addr_step;
                        state_d = RD_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            size_q   <= '0;
            fixed_q  <= 1'b0;
            err_q    <= 1'b0;
            last_w_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            size_q   <= size_d;
            fixed_q  <= fixed_d;
            err_q    <= err_d;
            last_w_q <= last_w_d;
        end
    end

    assign bus.awready = (state_q == IDLE) & grant_w;
    assign bus.arready = (state_q == IDLE) & grant_r;
    assign bus.wready  = (state_q == WR_DATA);
    assign bus.bvalid  = (state_q == WR_RESP);
    assign bus.bid     = id_q;
    assign bus.bresp   = err_q ? 2'b10 : 2'b00;
    assign bus.rvalid  = (state_q == RD_DATA);
    assign bus.rid     = id_q;
    assign bus.rresp   = err_q ? 2'b10 : 2'b00;
    assign bus.rlast   = bus.rvalid & beat_last;
    assign bus.rdata   = bus.rvalid ? mem_q : '0;

    assign mem_d    = bus.wdata;
    assign mem_wen  = bus.wready & bus.wvalid;
    assign mem_be   = bus.wready ? bus.wstrb : '0;
    assign mem_ceb  = (state_q == RD_REQ);
    assign mem_addr = addr_q & ~addr_wid'(stroblen - 1);
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a byte-array SRAM model behind the memory port.
module tb_axi_sram_slave;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axi_sram_slave_if #(.addr_wid(26), .data_wid(32), .id_wid(4)) bus ();

    logic [31:0] mem_d, mem_q;
    logic [25:0] mem_addr;
    logic        mem_wen, mem_ceb;
    logic [3:0]  mem_be;

    axi_sram_slave #(.addr_wid(26), .data_wid(32), .id_wid(4)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .bus      (bus),
        .mem_d    (mem_d),
        .mem_addr (mem_addr),
        .mem_wen  (mem_wen),
        .mem_be   (mem_be),
        .mem_ceb  (mem_ceb),
        .mem_q    (mem_q)
    );

    logic [7:0] sram [0:4095];
    always @(posedge aclk) begin
        if (mem_wen) begin
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) sram[int'(mem_addr[11:0]) + i] <= mem_d[8*i +: 8];
        end
        if (mem_ceb && !mem_wen) begin
            for (int i = 0; i < 4; i++) mem_q[8*i +: 8] <= sram[int'(mem_addr[11:0]) + i];
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [25:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size;
        bus.awburst = burst; bus.awvalid = 1'b1;
        do begin @(negedge aclk); n++; end while (!bus.awready && n < 20);
        check("awready", 64'(bus.awready), 64'd1);
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [25:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size;
        bus.arburst = burst; bus.arvalid = 1'b1;
        do begin @(negedge aclk); n++; end while (!bus.arready && n < 20);
        check("arready", 64'(bus.arready), 64'd1);
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last,
                          input int gap);
        int n = 0;
        repeat (gap) begin @(posedge aclk); #1; end
        bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
        do begin @(negedge aclk); n++; end while (!bus.wready && n < 20);
        check("wready", 64'(bus.wready), 64'd1);
        @(posedge aclk); #1;
        bus.wvalid = 1'b0;
    endtask

    task automatic b_recv(input logic [3:0] id, input logic [1:0] resp);
        int n = 0;
        bus.bready = 1'b1;
        do begin @(negedge aclk); n++; end while (!bus.bvalid && n < 20);
        check("bvalid", 64'(bus.bvalid), 64'd1);
        check("bid", 64'(bus.bid), 64'(id));
        check("bresp", 64'(bus.bresp), 64'(resp));
        @(posedge aclk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic r_recv(input logic [31:0] data, input logic [3:0] id, input logic [1:0] resp,
                          input logic last, input int stall);
        int n = 0;
        bus.rready = 1'b0;
        do begin @(negedge aclk); n++; end while (!bus.rvalid && n < 20);
        check("rvalid", 64'(bus.rvalid), 64'd1);
        repeat (stall) begin
            @(negedge aclk);
            check("rvalid_hold", 64'(bus.rvalid), 64'd1);
            check("rdata_hold", 64'(bus.rdata), 64'(data));
        end
        bus.rready = 1'b1;
        check("rdata", 64'(bus.rdata), 64'(data));
        check("rid", 64'(bus.rid), 64'(id));
        check("rresp", 64'(bus.rresp), 64'(resp));
        check("rlast", 64'(bus.rlast), 64'(last));
        @(posedge aclk); #1;
        bus.rready = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_awready"}, 64'(bus.awready), 64'd0);
        check({tag, "_arready"}, 64'(bus.arready), 64'd0);
        check({tag, "_wready"}, 64'(bus.wready), 64'd0);
        check({tag, "_bvalid"}, 64'(bus.bvalid), 64'd0);
        check({tag, "_rvalid"}, 64'(bus.rvalid), 64'd0);
        check({tag, "_rdata"}, 64'(bus.rdata), 64'd0);
        check({tag, "_bresp"}, 64'(bus.bresp), 64'd0);
        check({tag, "_rlast"}, 64'(bus.rlast), 64'd0);
        check({tag, "_mem_wen"}, 64'(mem_wen), 64'd0);
        check({tag, "_mem_be"}, 64'(mem_be), 64'd0);
        check({tag, "_mem_ceb"}, 64'(mem_ceb), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
        bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        repeat (3) @(posedge aclk);
        #1;
        check_idle_outputs("reset");
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // Simultaneous AW/AR after reset: write first, then read wins the next pair.
        bus.awid = 4'd1; bus.awaddr = 26'h40; bus.awlen = 8'd0; bus.awsize = 3'd2;
        bus.awburst = 2'b01; bus.awvalid = 1'b1;
        bus.arid = 4'd2; bus.araddr = 26'h40; bus.arlen = 8'd0; bus.arsize = 3'd2;
        bus.arburst = 2'b01; bus.arvalid = 1'b1;
        @(negedge aclk);
        check("arb1_awready", 64'(bus.awready), 64'd1);
        check("arb1_arready", 64'(bus.arready), 64'd0);
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
        w_beat(32'h12345678, 4'hF, 1'b1, 0);
        bus.awid = 4'd6; bus.awaddr = 26'h44; bus.awvalid = 1'b1;
        b_recv(4'd1, 2'b00);
        @(negedge aclk);
        check("arb2_arready", 64'(bus.arready), 64'd1);
        check("arb2_awready", 64'(bus.awready), 64'd0);
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
        r_recv(32'h12345678, 4'd2, 2'b00, 1'b1, 0);
        aw_send(4'd6, 26'h44, 8'd0, 3'd2, 2'b01);
        w_beat(32'hCAFEF00D, 4'hF, 1'b1, 0);
        b_recv(4'd6, 2'b00);

        // Single beat and read latency.
        aw_send(4'd3, 26'h10, 8'd0, 3'd2, 2'b01);
        w_beat(32'hDEADBEEF, 4'hF, 1'b1, 0);
        b_recv(4'd3, 2'b00);
        ar_send(4'd5, 26'h10, 8'd0, 3'd2, 2'b01);
        @(negedge aclk);
        check("lat_rvalid_n1", 64'(bus.rvalid), 64'd0);
        check("lat_mem_ceb_n1", 64'(mem_ceb), 64'd1);
        @(negedge aclk);
        check("lat_rvalid_n2", 64'(bus.rvalid), 64'd1);
        r_recv(32'hDEADBEEF, 4'd5, 2'b00, 1'b1, 0);

        // Partial strobe merge.
        aw_send(4'd7, 26'h10, 8'd0, 3'd2, 2'b01);
        w_beat(32'h11223344, 4'b0101, 1'b1, 0);
        b_recv(4'd7, 2'b00);
        ar_send(4'd7, 26'h10, 8'd0, 3'd2, 2'b01);
        r_recv(32'hDE22BE44, 4'd7, 2'b00, 1'b1, 0);

        // INCR burst with W gaps and R stalls.
        aw_send(4'd8, 26'h100, 8'd3, 3'd2, 2'b01);
        w_beat(32'd1, 4'hF, 1'b0, 0);
        w_beat(32'd2, 4'hF, 1'b0, 1);
        w_beat(32'd3, 4'hF, 1'b0, 0);
        w_beat(32'd4, 4'hF, 1'b1, 2);
        b_recv(4'd8, 2'b00);
        ar_send(4'd8, 26'h100, 8'd3, 3'd2, 2'b01);
        r_recv(32'd1, 4'd8, 2'b00, 1'b0, 2);
        r_recv(32'd2, 4'd8, 2'b00, 1'b0, 0);
        r_recv(32'd3, 4'd8, 2'b00, 1'b0, 1);
        r_recv(32'd4, 4'd8, 2'b00, 1'b1, 0);

        // FIXED burst overwrites one location.
        aw_send(4'd2, 26'h200, 8'd1, 3'd2, 2'b00);
        w_beat(32'hA, 4'hF, 1'b0, 0);
        w_beat(32'hB, 4'hF, 1'b1, 0);
        b_recv(4'd2, 2'b00);
        ar_send(4'd2, 26'h200, 8'd0, 3'd2, 2'b01);
        r_recv(32'hB, 4'd2, 2'b00, 1'b1, 0);

        // Early wlast: all beats still land, response is SLVERR.
        aw_send(4'd4, 26'h280, 8'd2, 3'd2, 2'b01);
        w_beat(32'h11, 4'hF, 1'b0, 0);
        w_beat(32'h22, 4'hF, 1'b1, 0);
        w_beat(32'h33, 4'hF, 1'b0, 0);
        b_recv(4'd4, 2'b10);
        ar_send(4'd4, 26'h280, 8'd2, 3'd2, 2'b01);
        r_recv(32'h11, 4'd4, 2'b00, 1'b0, 0);
        r_recv(32'h22, 4'd4, 2'b00, 1'b0, 0);
        r_recv(32'h33, 4'd4, 2'b00, 1'b1, 0);

        // Reserved burst type reads as INCR with SLVERR.
        ar_send(4'd9, 26'h100, 8'd3, 3'd2, 2'b11);
        r_recv(32'd1, 4'd9, 2'b10, 1'b0, 0);
        r_recv(32'd2, 4'd9, 2'b10, 1'b0, 0);
        r_recv(32'd3, 4'd9, 2'b10, 1'b0, 0);
        r_recv(32'd4, 4'd9, 2'b10, 1'b1, 0);

        // Reset in the middle of a 4-beat write.
        aw_send(4'd9, 26'h300, 8'd3, 3'd2, 2'b01);
        w_beat(32'h1, 4'hF, 1'b0, 0);
        w_beat(32'h2, 4'hF, 1'b0, 0);
        bus.wdata = 32'h3; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
        #1;
        check("midrst_mem_wen_pre", 64'(mem_wen), 64'd1);
        aresetn = 1'b0;
        #1;
        check_idle_outputs("midrst");
        bus.wvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        aw_send(4'd10, 26'h300, 8'd0, 3'd2, 2'b01);
        w_beat(32'h55AA55AA, 4'hF, 1'b1, 0);
        b_recv(4'd10, 2'b00);
        ar_send(4'd11, 26'h300, 8'd0, 3'd2, 2'b01);
        r_recv(32'h55AA55AA, 4'd11, 2'b00, 1'b1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI4 slave controller that accepts write and read bursts from an AXI master and drives the byte-addressed single-port SRAM interface (d/addr/wen/be/ceb/q). It is the initiator for the SRAM port and the responder for the AXI bus: it sequences burst beats into SRAM accesses and returns B and R responses. Only one transaction, read or write, is in flight at a time.

## Interface
- addr_wid, 26, AXI and SRAM byte address width
- data_wid, 32, data bus width (8, 16, 32 or 64)
- id_wid, 4, AXI ID width
- stroblen, data_wid/8, byte lanes
- aclk  in  1  clock; all state updates on the rising edge
- aresetn  in  1  reset, asynchronous, active-low
- awid/awaddr/awlen/awsize/awburst  in  id_wid/addr_wid/8/3/2  write address
- awvalid in 1, awready out 1  AW handshake
- wdata/wstrb/wlast  in  data_wid/stroblen/1  write data
- wvalid in 1, wready out 1  W handshake
- bid/bresp  out  id_wid/2  write response; bvalid out 1, bready in 1
- arid/araddr/arlen/arsize/arburst  in  same widths as AW  read address
- arvalid in 1, arready out 1  AR handshake
- rid/rdata/rresp/rlast  out  id_wid/data_wid/2/1  read data; rvalid out 1, rready in 1
- mem_d  out  data_wid  SRAM write data
- mem_addr  out  addr_wid  SRAM byte address, lane 0
- mem_wen  out  1  SRAM write enable
- mem_be  out  stroblen  SRAM byte enables
- mem_ceb  out  1  SRAM read enable
- mem_q  in  data_wid  SRAM read data, updated on the edge where mem_ceb=1 and mem_wen=0

## Operation
- States: IDLE, WR_DATA, WR_RESP, RD_REQ, RD_DATA.
- IDLE: awready=grant_w, arready=grant_r; both combinational. With only one valid, it is granted. With both valid, grant alternates; after reset, write wins first. The last-granted flag updates on every AW or AR handshake.
- AW handshake: latch awid/addr/len/size/burst, clear beat counter and error flag, go to WR_DATA. AR handshake: same latching with AR fields, go to RD_REQ.
- Beat address: mem_addr = current address with the low log2(stroblen) bits cleared. Lane i is written at mem_addr+i by the SRAM.
- Address update: INCR adds 2^size after each beat. FIXED keeps the address. Arithmetic is modulo 2^addr_wid, with no 4 KB boundary check.
- Errors: burst 2'b10 or 2'b11, or size > log2(stroblen), set the error flag. The transfer still proceeds as INCR at full width, and the response is SLVERR (2'b10) instead of OKAY (2'b00).
- WR_DATA: wready=1. mem_wen=wvalid, mem_d=wdata, mem_be=wstrb; all combinational. Each W handshake is one SRAM write at that same edge. The burst ends on beat len+1. If wlast does not equal (beat==len), the error flag is set. Then go to WR_RESP.
- WR_RESP: bvalid=1, bid=latched ID, bresp from the error flag. On bready, go to IDLE.
- RD_REQ: mem_ceb=1, mem_wen=0 for exactly one cycle, then go to RD_DATA.
- RD_DATA: rvalid=1, rdata=mem_q, rid=latched ID, rresp from the error flag, rlast=(beat==len).
  - On rready: if last, go to IDLE; otherwise advance the address and beat counter and go to RD_REQ.
  - mem_ceb=0 here, so mem_q holds while the bench stalls rready.
- Outside WR_DATA: mem_wen=0 and mem_be=0. Outside RD_REQ: mem_ceb=0.

## Timing
- Reset values (aresetn low): state IDLE; all ready, valid and mem_* strobes 0; bid, rid, bresp, rresp, rlast, rdata and mem_addr are 0.
- rdata is 0 whenever rvalid=0.
- Reset mid-burst abandons the transaction immediately, with no partial response. mem_wen drops asynchronously with the state.
- Write: AW handshake at edge N; wready=1 from cycle N+1. Throughput is 1 beat per cycle. bvalid asserts the cycle after the last W handshake.
- Read: AR handshake at edge N; RD_REQ in cycle N+1; rvalid in cycle N+2. Each later beat comes 2 cycles after the previous R handshake. Peak throughput is 1 beat per 2 cycles.
- AW/AR are not accepted outside IDLE. A new transaction can be accepted in the first IDLE cycle after B or the last R handshake.

## Test plan
- Reset: assert aresetn=0 mid-way through a 4-beat write -> all outputs take reset values and the controller returns to IDLE. A fresh single write then completes with bresp=OKAY.
- Single beat: write awaddr=0x10, len=0, size=2, INCR, wdata=0xDEADBEEF, wstrb=0xF, awid=3 -> bid=3, bresp=0. Reading 0x10 with arid=5 -> rdata=0xDEADBEEF, rid=5, rlast=1, rresp=0, rvalid exactly 2 cycles after AR.
- Partial strobe: write 0x11223344 with wstrb=0b0101 over 0xDEADBEEF at 0x10 -> readback 0xDE22BE44.
- Bursts:
  - INCR len=3 at 0x100 with data 1,2,3,4 and wvalid gaps -> readback 1,2,3,4 with rready toggled. rlast is on beat 4 only, and rvalid holds stable while rready=0.
  - FIXED len=1 at 0x200 with data 0xA then 0xB -> single read returns 0xB.
- Arbitration: AW and AR valid together after reset -> write granted first, then read. The next simultaneous pair is granted read first.
- Errors:
  - len=2 burst with wlast on beat 2 -> all 3 beats written, bresp=SLVERR.
  - arburst=2'b11 -> data returned as INCR with rresp=SLVERR on every beat.
